// File: rtl/button_command_gen.sv
// -----------------------------------------------------------------------------
// button_command_gen
//   Turns two raw, bouncing push-buttons into clean, mutually exclusive,
//   single-cycle Up/Down command pulses (one per press) for the up/down
//   counter. Each button goes through a 2-flop synchroniser and a debouncer.
//   A small FSM then arbitrates between the two debounced levels.
//
//   Optional feature (macro BUTTON_AUTOREPEAT_EN):
//     While a single button stays held, it emits repeat pulses in the same
//     direction. The first repeat comes REPEAT_DELAY cycles after the initial
//     pulse, then one every REPEAT_PERIOD cycles. With the macro undefined,
//     the repeat counter does not exist and each press gives exactly one pulse.
//
// Ports
//   Clock    in   system clock, rising edge
//   Reset    in   synchronous, active-high reset
//   Btn_Up   in   raw Up button (async, active-high, may bounce)
//   Btn_Down in   raw Down button (async, active-high, may bounce)
//   Up       out  one-cycle increment pulse (registered)
//   Down     out  one-cycle decrement pulse (registered)
//   Held     out  registered OR of both debounced levels
// -----------------------------------------------------------------------------

// Per-button lane: 2-flop synchroniser followed by a debouncer.
module button_command_gen_lane #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic deb
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

   logic          sync1, sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         deb   <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         // Any return to the current level restarts the stability window,
         // so a glitch shorter than DEBOUNCE_CYCLES never flips deb.
         if (sync2 == deb) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb <= ~deb;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module button_command_gen #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Btn_Up,
   input  logic Btn_Down,
   output logic Up,
   output logic Down,
   output logic Held
);
   localparam int NUM_LANES = 2;   // lane 0 = Up, lane 1 = Down

   typedef enum logic [1:0] {IDLE, UP_HELD, DOWN_HELD, BOTH_LOCK} state_t;

   logic [NUM_LANES-1:0] btn_raw, deb;
   logic                 deb_up, deb_down;
   state_t               state, state_nxt;
   logic                 up_nxt, down_nxt;

   // Reject nonsensical configurations at elaboration time.
   if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("button_command_gen: all cycle parameters must be >= 1");
   end

   assign btn_raw  = {Btn_Down, Btn_Up};
   assign deb_up   = deb[0];
   assign deb_down = deb[1];

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      button_command_gen_lane #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_lane (
         .clk(Clock),
         .rst(Reset),
         .raw(btn_raw[i]),
         .deb(deb[i])
      );
   end

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD) + 1;

   // The count runs 0..DELAY-1 up to the first repeat. After that it cycles
   // through DELAY..DELAY+PERIOD-1, so no separate "first repeat done" flag
   // is needed.
   logic [RW-1:0] rpt_cnt, rpt_nxt;
   logic          rpt_fire, rpt_wrap;

   assign rpt_wrap = (rpt_cnt == RW'(REPEAT_DELAY + REPEAT_PERIOD - 1));
   assign rpt_fire = (rpt_cnt == RW'(REPEAT_DELAY - 1)) || rpt_wrap;
`endif

   // IDLE is entered only with both levels low, so testing the levels there
   // is the same as detecting their rising edges.
   always_comb begin
      state_nxt = state;
      up_nxt    = 1'b0;
      down_nxt  = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt_nxt   = '0;   // cleared in every state except a continuing hold
`endif
      case (state)
         IDLE: begin
            if (deb_up && deb_down) begin
               state_nxt = BOTH_LOCK;
            end else if (deb_up) begin
               up_nxt    = 1'b1;
               state_nxt = UP_HELD;
            end else if (deb_down) begin
               down_nxt  = 1'b1;
               state_nxt = DOWN_HELD;
            end
         end
         UP_HELD: begin
            if (deb_down) begin
               state_nxt = BOTH_LOCK;
            end else if (!deb_up) begin
               state_nxt = IDLE;
            end else begin
`ifdef BUTTON_AUTOREPEAT_EN
               up_nxt  = rpt_fire;
               rpt_nxt = rpt_wrap ? RW'(REPEAT_DELAY) : rpt_cnt + RW'(1);
`endif
            end
         end
         DOWN_HELD: begin
            if (deb_up) begin
               state_nxt = BOTH_LOCK;
            end else if (!deb_down) begin
               state_nxt = IDLE;
            end else begin
`ifdef BUTTON_AUTOREPEAT_EN
               down_nxt = rpt_fire;
               rpt_nxt  = rpt_wrap ? RW'(REPEAT_DELAY) : rpt_cnt + RW'(1);
`endif
            end
         end
         BOTH_LOCK: begin
            if (!deb_up && !deb_down) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         Up      <= 1'b0;
         Down    <= 1'b0;
         Held    <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
         rpt_cnt <= '0;
`endif
      end else begin
         state   <= state_nxt;
         Up      <= up_nxt;
         Down    <= down_nxt;
         Held    <= deb_up | deb_down;
`ifdef BUTTON_AUTOREPEAT_EN
         rpt_cnt <= rpt_nxt;
`endif
      end
   end
endmodule

// File: tb/tb_button_command_gen.sv
// Directed bench for button_command_gen, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Inputs change 1 time unit after a rising edge (edge E).
// The first edge that samples them is E+1, so a stable press shows on Up/Down
// in the cycle after edge E+7. A release shows on Held after edge E+7.
module tb_button_command_gen;
   logic clk = 1'b0;
   logic rst, btn_up, btn_down;
   logic up, down, held;

   int checks = 0;
   int errors = 0;
   int n_up = 0, n_down = 0;
   logic both_seen = 1'b0;
   int u0, d0;

   button_command_gen #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(20),
      .REPEAT_PERIOD(8)
   ) dut (
      .Clock(clk),
      .Reset(rst),
      .Btn_Up(btn_up),
      .Btn_Down(btn_down),
      .Up(up),
      .Down(down),
      .Held(held)
   );

   always #5 clk = ~clk;

   // Pulse counters and an overlap monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (up === 1'b1)   n_up++;
      if (down === 1'b1) n_down++;
      if (up === 1'b1 && down === 1'b1) both_seen = 1'b1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic eu, input logic ed, input logic eh);
      chk({tag, ".up"}, 32'(up), 32'(eu));
      chk({tag, ".down"}, 32'(down), 32'(ed));
      chk({tag, ".held"}, 32'(held), 32'(eh));
   endtask

   initial begin
      int exp_rep;
      logic e;
      // ---- 1: reset with both buttons pressed, then release ----
      rst = 1'b1; btn_up = 1'b1; btn_down = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk_outs("rst_hold", 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk_outs("rst_idle", 1'b0, 1'b0, 1'b0);
      end

      // ---- 2: clean Up press held 40 cycles ----
      u0 = n_up; d0 = n_down;
      btn_up = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick(1);
         chk_outs("t2_pre", 1'b0, 1'b0, 1'b0);
      end
      tick(1); chk_outs("t2_pulse", 1'b1, 1'b0, 1'b1);
      tick(1); chk_outs("t2_after", 1'b0, 1'b0, 1'b1);
      tick(32); chk("t2_held40", 32'(held), 32'd1);
      btn_up = 1'b0;
      tick(6); chk("t2_rel6", 32'(held), 32'd1);
      tick(1); chk("t2_rel7", 32'(held), 32'd0);
`ifdef BUTTON_AUTOREPEAT_EN
      exp_rep = 3;   // repeats at +20, +28, +36 from the first pulse
`else
      exp_rep = 0;
`endif
      chk("t2_nup", 32'(n_up - u0), 32'(1 + exp_rep));
      chk("t2_ndown", 32'(n_down - d0), 32'd0);
      tick(5);

      // ---- 3: bouncing Up press, stable from E+8 ----
      u0 = n_up;
      btn_up = 1'b1; tick(2);
      btn_up = 1'b0; tick(2);
      btn_up = 1'b1; tick(2);
      btn_up = 1'b0; tick(2);
      btn_up = 1'b1;
      tick(6); chk_outs("t3_pre", 1'b0, 1'b0, 1'b0);
      tick(1); chk_outs("t3_pulse", 1'b1, 1'b0, 1'b1);
      tick(1); chk("t3_after", 32'(up), 32'd0);
      tick(10); btn_up = 1'b0;
      tick(12);
      chk("t3_nup", 32'(n_up - u0), 32'd1);

      // ---- 4: both pressed on the same edge -> lock, then Down alone ----
      u0 = n_up; d0 = n_down;
      btn_up = 1'b1; btn_down = 1'b1;
      tick(7); chk_outs("t4_lock", 1'b0, 1'b0, 1'b1);
      tick(13); btn_up = 1'b0; btn_down = 1'b0;
      tick(12);
      chk("t4_nup", 32'(n_up - u0), 32'd0);
      chk("t4_ndown", 32'(n_down - d0), 32'd0);
      chk("t4_held_off", 32'(held), 32'd0);
      btn_down = 1'b1;
      tick(6); chk("t4_dpre", 32'(down), 32'd0);
      tick(1); chk_outs("t4_dpulse", 1'b0, 1'b1, 1'b1);
      tick(1); chk("t4_dafter", 32'(down), 32'd0);
      tick(2); btn_down = 1'b0;
      tick(12);
      chk("t4_ndown2", 32'(n_down - d0), 32'd1);

      // ---- 5: Up held, Down joins, release Up then Down ----
      u0 = n_up; d0 = n_down;
      btn_up = 1'b1;
      tick(15); btn_down = 1'b1;
      tick(15); btn_up = 1'b0;
      tick(10); btn_down = 1'b0;
      tick(6); chk("t5_rel6", 32'(held), 32'd1);
      tick(1); chk("t5_rel7", 32'(held), 32'd0);
      tick(5);
      chk("t5_nup", 32'(n_up - u0), 32'd1);
      chk("t5_ndown", 32'(n_down - d0), 32'd0);
      // A lone Down press pulses only if the FSM is back in IDLE.
      btn_down = 1'b1;
      tick(7); chk("t5_idle_down", 32'(down), 32'd1);
      tick(3); btn_down = 1'b0;
      tick(12);

      // ---- 6: reset mid-hold, released with Up still pressed ----
      btn_up = 1'b1;
      tick(10);
      rst = 1'b1;
      tick(1); chk_outs("t6_rst", 1'b0, 1'b0, 1'b0);
      tick(3); chk_outs("t6_rst4", 1'b0, 1'b0, 1'b0);
      u0 = n_up;
      rst = 1'b0;
      tick(6); chk("t6_pre", 32'(up), 32'd0);
      tick(1); chk_outs("t6_pulse", 1'b1, 1'b0, 1'b1);
      for (int k = 1; k <= 52; k++) begin
         tick(1);
`ifdef BUTTON_AUTOREPEAT_EN
         e = (k == 20 || k == 28 || k == 36 || k == 44 || k == 52);
`else
         e = 1'b0;
`endif
         chk($sformatf("t6_rep%0d", k), 32'(up), 32'(e));
      end
      btn_up = 1'b0;
      tick(12);
`ifdef BUTTON_AUTOREPEAT_EN
      exp_rep = 5;
`else
      exp_rep = 0;
`endif
      chk("t6_nup", 32'(n_up - u0), 32'(1 + exp_rep));
      chk_outs("t6_end", 1'b0, 1'b0, 1'b0);

      chk("no_overlap", 32'(both_seen), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
